fib_matpow_ctrl: RTL
====================

Name: fib_matpow_ctrl

Overview:
Sequential controller that computes Fibonacci F(n) mod 2^WIDTH by square-and-multiply exponentiation of the 2x2 matrix Q = [[1,1],[1,0]]. It owns a result matrix R, a power matrix M and an exponent shift register. It time-shares a single combinational 2x2 matrix multiplier between the R*M and M*M updates. It sits as a start/done coprocessor beside the CPU datapath: the CPU issues n and later collects F(n).

Parameters:
WIDTH, 32, element/operand/result width; all arithmetic is modulo 2^WIDTH.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only in IDLE.
n_in  in  WIDTH  exponent n; captured on the accepted start.
busy  out  1  high in MUL, SQR, FIN; low in IDLE.
done  out  1  one-cycle pulse, high exactly while in FIN.
result  out  WIDTH  F(n) mod 2^WIDTH; holds until the next FIN.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=0, R=I, M=Q, n_reg=0.
- States: IDLE, MUL, SQR, FIN. Registers: R[0..3], M[0..3], n_reg, all WIDTH bits, row-major [a,b,c,d].
- IDLE: on start=1, load n_reg<=n_in, R<=I=[1,0,0,1], M<=Q=[1,1,1,0].
  - If n_in==0, go to FIN.
  - Otherwise go to MUL.
  - If start=0, stay in IDLE.
- MUL: the multiplier operands are (R,M).
  - If n_reg[0]=1, R<=R*M.
  - Else R holds.
  - Always go to SQR. This state costs 1 cycle regardless of the bit value.
- SQR: the multiplier operands are (M,M).
  - M<=M*M; n_reg<=n_reg>>1.
  - If (n_reg>>1)==0, go to FIN; else go to MUL.
- FIN: result<=R[1] (0 when n==0, since R=I). done=1. Go to IDLE next cycle.
- Multiplier operand mux is selected purely by state. In IDLE and FIN the operands are don't-care and no register updates from the product.
- Latency: let L = bit length of n (position of the MSB + 1).
  - For n>0, done is high in cycle 2L+1 after the start edge (2L cycles of MUL/SQR, then FIN).
  - For n==0, done is high in the cycle immediately after the start edge.
  - Worst case n=2^WIDTH-1 gives 2*WIDTH+1 cycles.
- Arithmetic: each product element is (x*y + z*w) truncated to WIDTH bits. Intermediate products are truncated to WIDTH; no saturation or overflow flag.
- The R*M update uses the old R and M values simultaneously (full combinational product, registered together). No element-by-element in-place update.
- start while busy=1, including during FIN: ignored, not queued. Back-to-back operation is possible by asserting start in the IDLE cycle following FIN.
- n_in changes after acceptance: no effect.
- Reset mid-operation: immediate abort to the reset state. result is cleared to 0 and no done pulse is issued.

Decomposition:
- Shared package fib_pkg holds:
  - WIDTH default;
  - state encoding constants ST_IDLE=2'd0, ST_MUL=2'd1, ST_SQR=2'd2, ST_FIN=2'd3;
  - constant matrices MAT_I and MAT_Q as element constants.
- Sub-module mat2_mul (parameter WIDTH): purely combinational.
  - Inputs a0..a3, b0..b3; outputs p0..p3 = A*B mod 2^WIDTH.
  - Instantiated once in fib_matpow_ctrl, with the operand mux in the controller.

Test Plan:
- Reset then n_in=0, start for 1 cycle -> done pulse 1 cycle after the start edge, result=0, busy high for exactly 1 cycle.
- n_in=1 -> done at cycle 3 after the start edge, result=1. n_in=2 -> done at cycle 5, result=1.
- n_in=10 (L=4) -> done at cycle 9, result=55. n_in=47 -> result=2971215073 (0xB11924E1).
- n_in=48 -> result=512559680 (wraps mod 2^32). n_in=0xFFFFFFFF -> done at cycle 65; compare against the software model.
- Assert start again with n_in=5 at cycles 2..6 of an n_in=10 run -> ignored, result=55. Then start n_in=5 in the following IDLE cycle -> result=5, done 7 cycles later.
- rst_n low for 1 cycle mid-run of n_in=20 -> busy, done and result go to 0 immediately with no done pulse. A subsequent n_in=20 run gives result=6765.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci matrix-power controller: default width,
// FSM state codes and the constant 2x2 matrices (row-major [a,b,c,d], one bit per element).
package fib_pkg;

  localparam int unsigned FIB_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_SQR  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Element e of a matrix is bit [e]; every element is either 0 or 1.
  localparam logic [0:3] MAT_I = 4'b1001;
  localparam logic [0:3] MAT_Q = 4'b1110;

endpackage

// File: rtl/fib_matpow_ctrl_mat2_mul.sv
// Combinational 2x2 matrix product P = A*B, row-major, all arithmetic mod 2^WIDTH.
module mat2_mul
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] b3,
  output logic [WIDTH-1:0] p0,
  output logic [WIDTH-1:0] p1,
  output logic [WIDTH-1:0] p2,
  output logic [WIDTH-1:0] p3
);

  assign p0 = a0 * b0 + a1 * b2;
  assign p1 = a0 * b1 + a1 * b3;
  assign p2 = a2 * b0 + a3 * b2;
  assign p3 = a2 * b1 + a3 * b3;

endmodule

// File: rtl/fib_matpow_ctrl.sv
// Start/done coprocessor computing F(n) mod 2^WIDTH by square-and-multiply of Q=[[1,1],[1,0]],
// sharing one combinational 2x2 multiplier between the R*M and M*M steps.
module fib_matpow_ctrl
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q [4];
  logic [WIDTH-1:0] r_d [4];
  logic [WIDTH-1:0] m_q [4];
  logic [WIDTH-1:0] m_d [4];
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] op_a [4];
  logic [WIDTH-1:0] op_b [4];
  logic [WIDTH-1:0] prod [4];

  // Left operand is M only while squaring; outside MUL/SQR the product is unused.
  always_comb begin
    op_b = m_q;
    op_a = (state_q == ST_SQR) ? m_q : r_q;
  end

  mat2_mul #(.WIDTH(WIDTH)) u_mul (
    .a0(op_a[0]), .a1(op_a[1]), .a2(op_a[2]), .a3(op_a[3]),
    .b0(op_b[0]), .b1(op_b[1]), .b2(op_b[2]), .b3(op_b[3]),
    .p0(prod[0]), .p1(prod[1]), .p2(prod[2]), .p3(prod[3])
  );

  // result is loaded on entry to FIN so it already equals R[1] while done is high.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    m_d      = m_q;
    n_d      = n_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d = n_in;
          for (int unsigned e = 0; e < 4; e++) begin
            r_d[e[1:0]] = WIDTH'(MAT_I[e[1:0]]);
            m_d[e[1:0]] = WIDTH'(MAT_Q[e[1:0]]);
          end
          if (n_in == '0) begin
            state_d  = ST_FIN;
            result_d = WIDTH'(MAT_I[1]);
          end else begin
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (n_q[0]) r_d = prod;
        state_d = ST_SQR;
      end
      ST_SQR: begin
        m_d = prod;
        n_d = n_q >> 1;
        if ((n_q >> 1) == '0) begin
          state_d  = ST_FIN;
          result_d = r_q[1];
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      result_q <= '0;
      for (int unsigned e = 0; e < 4; e++) begin
        r_q[e[1:0]] <= WIDTH'(MAT_I[e[1:0]]);
        m_q[e[1:0]] <= WIDTH'(MAT_Q[e[1:0]]);
      end
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      m_q      <= m_d;
      n_q      <= n_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_FIN);
  assign result = result_q;

endmodule
